// File: rtl/dll_pkg.sv
// Shared DLL types: DLCMSM link states, TX arbiter FSM states and TX source indices.
package dll_pkg;

    typedef enum logic [1:0] {
        DL_INACTIVE = 2'b00,
        DL_INIT     = 2'b01,
        DL_ACTIVE   = 2'b10
    } dlcm_state_t;

    typedef enum logic [1:0] {
        IDLE,
        LOCK_RPL,
        LOCK_TLP
    } tx_arb_state_t;

    localparam int unsigned SRC_ACK = 0;
    localparam int unsigned SRC_FC  = 1;
    localparam int unsigned SRC_RPL = 2;
    localparam int unsigned SRC_TLP = 3;
    localparam int unsigned NUM_SRC = 4;

endpackage

// File: rtl/dll_tx_fc_aging.sv
// Counts how long a pending FC DLLP has been refused and flags it for promotion.
module dll_tx_fc_aging #(
    parameter int unsigned FC_MAX_WAIT  = 64,
    parameter int unsigned FC_WAIT_BITS = 8
) (
    input  logic sclk,
    input  logic srst,
    input  logic fc_valid,
    input  logic fc_ready,
    output logic promote
);

    localparam logic [FC_WAIT_BITS-1:0] WAIT_MAX = FC_WAIT_BITS'(FC_MAX_WAIT);

    logic [FC_WAIT_BITS-1:0] fc_wait;

    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            fc_wait <= '0;
        end else if (!fc_valid || fc_ready) begin
            fc_wait <= '0;
        end else if (fc_wait != WAIT_MAX) begin
            fc_wait <= fc_wait + 1'b1;
        end
    end

    assign promote = (fc_wait == WAIT_MAX);

endmodule

// File: rtl/dll_tx_arbiter.sv
// Arbitrates ACK/NAK, FC, replay and new-TLP beats onto the single registered PIPE TX stream.
module dll_tx_arbiter
    import dll_pkg::*;
#(
    parameter int unsigned PIPE_DATA_WIDTH = 256,
    parameter int unsigned FC_MAX_WAIT     = 64,
    parameter int unsigned FC_WAIT_BITS    = 8
) (
    input  logic                       sclk,
    input  logic                       srst,
    input  logic [1:0]                 dlcmsm_i,
    input  logic                       ack_valid_i,
    input  logic [PIPE_DATA_WIDTH-1:0] ack_data_i,
    output logic                       ack_ready_o,
    input  logic                       fc_valid_i,
    input  logic [PIPE_DATA_WIDTH-1:0] fc_data_i,
    output logic                       fc_ready_o,
    input  logic                       rpl_valid_i,
    input  logic [PIPE_DATA_WIDTH-1:0] rpl_data_i,
    input  logic                       rpl_last_i,
    output logic                       rpl_ready_o,
    input  logic                       tlp_valid_i,
    input  logic [PIPE_DATA_WIDTH-1:0] tlp_data_i,
    input  logic                       tlp_last_i,
    output logic                       tlp_ready_o,
    output logic [PIPE_DATA_WIDTH-1:0] pipe_txdata_o,
    output logic                       pipe_txvalid_o,
    output logic                       fc_starved_o
);

    tx_arb_state_t              state, next_state;
    logic [NUM_SRC-1:0]         grant;
    logic [NUM_SRC-1:0]         valid;
    logic [NUM_SRC-1:0]         accept;
    logic [PIPE_DATA_WIDTH-1:0] beat;
    logic                       link_active, link_init;
    logic                       fc_promote;

    assign link_active = (dlcmsm_i == DL_ACTIVE);
    assign link_init   = (dlcmsm_i == DL_INIT);

    dll_tx_fc_aging #(
        .FC_MAX_WAIT  (FC_MAX_WAIT),
        .FC_WAIT_BITS (FC_WAIT_BITS)
    ) u_fc_aging (
        .sclk     (sclk),
        .srst     (srst),
        .fc_valid (fc_valid_i),
        .fc_ready (fc_ready_o),
        .promote  (fc_promote)
    );

    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Readies are gated by srst so every output reads 0 while reset is held.
    always_comb begin
        grant      = '0;
        next_state = state;
        if (srst || (!link_active && !link_init)) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (link_init) begin
                        grant[SRC_FC] = fc_valid_i;
                    end else if (fc_promote && fc_valid_i) begin
                        grant[SRC_FC] = 1'b1;
                    end else if (ack_valid_i) begin
                        grant[SRC_ACK] = 1'b1;
                    end else if (rpl_valid_i) begin
                        grant[SRC_RPL] = 1'b1;
                        if (!rpl_last_i) next_state = LOCK_RPL;
                    end else if (tlp_valid_i) begin
                        grant[SRC_TLP] = 1'b1;
                        if (!tlp_last_i) next_state = LOCK_TLP;
                    end else if (fc_valid_i) begin
                        grant[SRC_FC] = 1'b1;
                    end
                end
                LOCK_RPL: begin
                    if (link_active) begin
                        grant[SRC_RPL] = 1'b1;
                        if (rpl_valid_i && rpl_last_i) next_state = IDLE;
                    end else begin
                        next_state = IDLE;
                    end
                end
                LOCK_TLP: begin
                    if (link_active) begin
                        grant[SRC_TLP] = 1'b1;
                        if (tlp_valid_i && tlp_last_i) next_state = IDLE;
                    end else begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    assign ack_ready_o  = grant[SRC_ACK];
    assign fc_ready_o   = grant[SRC_FC];
    assign rpl_ready_o  = grant[SRC_RPL];
    assign tlp_ready_o  = grant[SRC_TLP];
    assign fc_starved_o = fc_promote;

    always_comb begin
        valid          = '0;
        valid[SRC_ACK] = ack_valid_i;
        valid[SRC_FC]  = fc_valid_i;
        valid[SRC_RPL] = rpl_valid_i;
        valid[SRC_TLP] = tlp_valid_i;
    end

    assign accept = grant & valid;

    always_comb begin
        beat = '0;
        if (accept[SRC_ACK]) beat = ack_data_i;
        if (accept[SRC_FC])  beat = fc_data_i;
        if (accept[SRC_RPL]) beat = rpl_data_i;
        if (accept[SRC_TLP]) beat = tlp_data_i;
    end

    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            pipe_txdata_o  <= '0;
            pipe_txvalid_o <= 1'b0;
        end else begin
            pipe_txvalid_o <= |accept;
            if (|accept) pipe_txdata_o <= beat;
        end
    end

endmodule

// File: tb/tb_dll_tx_arbiter.sv
// Directed bench for dll_tx_arbiter: priorities, packet locking, FC aging, DLCMSM gating, reset.
module tb_dll_tx_arbiter;

    localparam int unsigned W = 32;

    logic         sclk = 1'b0;
    logic         srst;
    logic [1:0]   dlcmsm_i;
    logic         ack_valid_i, fc_valid_i, rpl_valid_i, tlp_valid_i;
    logic [W-1:0] ack_data_i, fc_data_i, rpl_data_i, tlp_data_i;
    logic         rpl_last_i, tlp_last_i;
    logic         ack_ready_o, fc_ready_o, rpl_ready_o, tlp_ready_o;
    logic [W-1:0] pipe_txdata_o;
    logic         pipe_txvalid_o, fc_starved_o;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    always #5 sclk = ~sclk;

    dll_tx_arbiter #(
        .PIPE_DATA_WIDTH (W),
        .FC_MAX_WAIT     (4),
        .FC_WAIT_BITS    (8)
    ) u_dut (
        .sclk           (sclk),
        .srst           (srst),
        .dlcmsm_i       (dlcmsm_i),
        .ack_valid_i    (ack_valid_i),
        .ack_data_i     (ack_data_i),
        .ack_ready_o    (ack_ready_o),
        .fc_valid_i     (fc_valid_i),
        .fc_data_i      (fc_data_i),
        .fc_ready_o     (fc_ready_o),
        .rpl_valid_i    (rpl_valid_i),
        .rpl_data_i     (rpl_data_i),
        .rpl_last_i     (rpl_last_i),
        .rpl_ready_o    (rpl_ready_o),
        .tlp_valid_i    (tlp_valid_i),
        .tlp_data_i     (tlp_data_i),
        .tlp_last_i     (tlp_last_i),
        .tlp_ready_o    (tlp_ready_o),
        .pipe_txdata_o  (pipe_txdata_o),
        .pipe_txvalid_o (pipe_txvalid_o),
        .fc_starved_o   (fc_starved_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // readies in order ack, fc, rpl, tlp
    task automatic chk_rdy(input string tag, input logic [3:0] exp);
        chk(tag, {ack_ready_o, fc_ready_o, rpl_ready_o, tlp_ready_o}, exp);
    endtask

    task automatic chk_pipe(input string tag, input logic v, input logic [W-1:0] d);
        chk(tag, {pipe_txvalid_o, pipe_txdata_o}, {v, d});
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic clear_valids();
        ack_valid_i = 1'b0; fc_valid_i = 1'b0; rpl_valid_i = 1'b0; tlp_valid_i = 1'b0;
        rpl_last_i  = 1'b0; tlp_last_i = 1'b0;
    endtask

    initial begin
        srst = 1'b1;
        dlcmsm_i = 2'b10;
        clear_valids();
        ack_data_i = '0; fc_data_i = '0; rpl_data_i = '0; tlp_data_i = '0;
        tick(); tick();
        chk("rst_pipe", {pipe_txvalid_o, pipe_txdata_o, fc_starved_o}, '0);
        chk_rdy("rst_rdy", 4'b0000);
        srst = 1'b0;

        // 3-beat TLP with ACK arriving mid-packet
        tlp_valid_i = 1; tlp_data_i = 32'h7000_0001; tlp_last_i = 0;
        #1 chk_rdy("t1_b1_rdy", 4'b0001);
        tick(); chk_pipe("t1_b1_pipe", 1, 32'h7000_0001);
        tlp_data_i = 32'h7000_0002; ack_valid_i = 1; ack_data_i = 32'hA000_0001;
        #1 chk_rdy("t1_b2_rdy", 4'b0001);
        tick(); chk_pipe("t1_b2_pipe", 1, 32'h7000_0002);
        tlp_data_i = 32'h7000_0003; tlp_last_i = 1;
        #1 chk_rdy("t1_b3_rdy", 4'b0001);
        tick(); chk_pipe("t1_b3_pipe", 1, 32'h7000_0003);
        tlp_valid_i = 0; tlp_last_i = 0;
        #1 chk_rdy("t1_ack_rdy", 4'b1000);
        tick(); chk_pipe("t1_ack_pipe", 1, 32'hA000_0001);
        clear_valids();
        #1 chk_rdy("t1_idle_rdy", 4'b0000);
        tick(); chk_pipe("t1_idle_pipe", 0, 32'hA000_0001);

        // replay precedence over new TLP
        rpl_valid_i = 1; rpl_data_i = 32'h5000_0001; rpl_last_i = 0;
        tlp_valid_i = 1; tlp_data_i = 32'h7100_0001; tlp_last_i = 1;
        #1 chk_rdy("t2_r1_rdy", 4'b0010);
        tick(); chk_pipe("t2_r1_pipe", 1, 32'h5000_0001);
        rpl_data_i = 32'h5000_0002; rpl_last_i = 1;
        #1 chk_rdy("t2_r2_rdy", 4'b0010);
        tick(); chk_pipe("t2_r2_pipe", 1, 32'h5000_0002);
        rpl_data_i = 32'h5000_0003;
        #1 chk_rdy("t2_r3_rdy", 4'b0010);
        tick(); chk_pipe("t2_r3_pipe", 1, 32'h5000_0003);
        rpl_valid_i = 0; rpl_last_i = 0;
        #1 chk_rdy("t2_tlp_rdy", 4'b0001);
        tick(); chk_pipe("t2_tlp_pipe", 1, 32'h7100_0001);
        clear_valids();
        #1 chk_rdy("t2_idle_rdy", 4'b0000);
        tick();

        // FC aging behind a stream of 2-beat TLPs
        fc_valid_i = 1; fc_data_i = 32'hF000_0001;
        tlp_valid_i = 1; tlp_data_i = 32'h7200_0001; tlp_last_i = 0;
        #1 chk_rdy("t3_c1_rdy", 4'b0001);
        tick();
        tlp_data_i = 32'h7200_0002; tlp_last_i = 1;
        #1 chk_rdy("t3_c2_rdy", 4'b0001);
        tick();
        tlp_data_i = 32'h7200_0003; tlp_last_i = 0;
        #1 chk_rdy("t3_c3_rdy", 4'b0001);
        tick();
        tlp_data_i = 32'h7200_0004; tlp_last_i = 1;
        #1 chk("t3_c4_starved", fc_starved_o, 1'b0);
        tick(); chk_pipe("t3_c4_pipe", 1, 32'h7200_0004);
        tlp_data_i = 32'h7200_0005; tlp_last_i = 0;
        ack_valid_i = 1; ack_data_i = 32'hA000_0002;
        #1 chk("t3_c5_starved", fc_starved_o, 1'b1);
        chk_rdy("t3_c5_rdy", 4'b0100);
        tick(); chk_pipe("t3_c5_pipe", 1, 32'hF000_0001);
        chk("t3_c6_starved", fc_starved_o, 1'b0);
        fc_valid_i = 0;
        #1 chk_rdy("t3_c6_rdy", 4'b1000);
        tick(); chk_pipe("t3_c6_pipe", 1, 32'hA000_0002);
        ack_valid_i = 0; tlp_last_i = 1;
        #1 chk_rdy("t3_c7_rdy", 4'b0001);
        tick(); chk_pipe("t3_c7_pipe", 1, 32'h7200_0005);
        clear_valids();
        tick();

        // INIT link state: FC only
        dlcmsm_i = 2'b01;
        ack_valid_i = 1; ack_data_i = 32'hA000_0003;
        tlp_valid_i = 1; tlp_data_i = 32'h7300_0001; tlp_last_i = 1;
        fc_valid_i = 1; fc_data_i = 32'hF000_0002;
        #1 chk_rdy("t4_init_rdy", 4'b0100);
        tick(); chk_pipe("t4_init_pipe", 1, 32'hF000_0002);
        fc_valid_i = 0;
        #1 chk_rdy("t4_init_nofc_rdy", 4'b0000);
        tick(); chk_pipe("t4_init_nofc_pipe", 0, 32'hF000_0002);
        dlcmsm_i = 2'b10;
        #1 chk_rdy("t4_act_ack_rdy", 4'b1000);
        tick(); chk_pipe("t4_act_ack_pipe", 1, 32'hA000_0003);
        ack_valid_i = 0;
        #1 chk_rdy("t4_act_tlp_rdy", 4'b0001);
        tick(); chk_pipe("t4_act_tlp_pipe", 1, 32'h7300_0001);
        clear_valids();
        dlcmsm_i = 2'b11; ack_valid_i = 1;
        #1 chk_rdy("t4_state11_rdy", 4'b0000);
        tick(); chk_pipe("t4_state11_pipe", 0, 32'h7300_0001);
        clear_valids();
        dlcmsm_i = 2'b10;

        // INACTIVE mid-packet abandons the TLP
        tlp_valid_i = 1; tlp_data_i = 32'h7400_0001; tlp_last_i = 0;
        #1 chk_rdy("t5_b1_rdy", 4'b0001);
        tick(); chk_pipe("t5_b1_pipe", 1, 32'h7400_0001);
        dlcmsm_i = 2'b00; tlp_data_i = 32'h7400_0002;
        #1 chk_rdy("t5_inact_rdy", 4'b0000);
        tick(); chk_pipe("t5_inact_pipe", 0, 32'h7400_0001);
        dlcmsm_i = 2'b10; tlp_data_i = 32'h7500_0001;
        ack_valid_i = 1; ack_data_i = 32'hA000_0004;
        #1 chk_rdy("t5_reidle_rdy", 4'b1000);
        tick(); chk_pipe("t5_reidle_pipe", 1, 32'hA000_0004);
        ack_valid_i = 0;
        #1 chk_rdy("t5_fresh_rdy", 4'b0001);
        tick(); chk_pipe("t5_fresh_pipe", 1, 32'h7500_0001);
        tlp_data_i = 32'h7500_0002; tlp_last_i = 1;
        #1 chk_rdy("t5_fresh_b2_rdy", 4'b0001);
        tick();
        clear_valids();
        tick();

        // reset pulse in LOCK_RPL
        fc_valid_i = 1; fc_data_i = 32'hF000_0003;
        rpl_valid_i = 1; rpl_data_i = 32'h5100_0001; rpl_last_i = 0;
        #1 chk_rdy("t6_r1_rdy", 4'b0010);
        tick();
        rpl_data_i = 32'h5100_0002;
        #1 chk_rdy("t6_r2_rdy", 4'b0010);
        tick(); chk_pipe("t6_r2_pipe", 1, 32'h5100_0002);
        srst = 1'b1;
        #1 chk_pipe("t6_rst_pipe", 0, '0);
        chk_rdy("t6_rst_rdy", 4'b0000);
        chk("t6_rst_starved", fc_starved_o, 1'b0);
        srst = 1'b0;
        ack_valid_i = 1; ack_data_i = 32'hA000_0005;
        #1 chk_rdy("t6_d1_rdy", 4'b1000);
        tick(); chk_pipe("t6_d1_pipe", 1, 32'hA000_0005);
        ack_valid_i = 0; rpl_data_i = 32'h5200_0001; rpl_last_i = 1;
        #1 chk_rdy("t6_d2_rdy", 4'b0010);
        tick();
        rpl_valid_i = 0; rpl_last_i = 0;
        tlp_valid_i = 1; tlp_data_i = 32'h7600_0001; tlp_last_i = 1;
        #1 chk("t6_d3_starved", fc_starved_o, 1'b0);
        chk_rdy("t6_d3_rdy", 4'b0001);
        tick();
        #1 chk("t6_d4_starved", fc_starved_o, 1'b0);
        tick();
        #1 chk("t6_d5_starved", fc_starved_o, 1'b1);
        chk_rdy("t6_d5_rdy", 4'b0100);
        tick(); chk_pipe("t6_d5_pipe", 1, 32'hF000_0003);
        clear_valids();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dll_tx_arbiter.md
Name: dll_tx_arbiter

Overview:
- Schedules the single PIPE TX beat stream between four DLL transmit sources.
  - ACK/NAK DLLPs.
  - InitFC/UpdateFC DLLPs.
  - Replay TLPs from the retry buffer.
  - New TLPs.
- Sits between the DLL write path, the DLL read path's DLLP generator and the PIPE TX interface.
- Gates traffic by DLCMSM state.
- Keeps multi-beat TLPs atomic.
- Bounds the wait of FC DLLPs behind TLP traffic.

Parameters:
- PIPE_DATA_WIDTH, 256: beat width in bits.
- FC_MAX_WAIT, 64: cycles a pending FC DLLP may wait before it is promoted to top priority.
- FC_WAIT_BITS, 8: width of the FC wait counter; must satisfy FC_WAIT_BITS ≥ clog2(FC_MAX_WAIT+1).

Ports:
- sclk  in  1  clock.
- srst  in  1  reset; asynchronous, active-high.
- dlcmsm_i  in  2  link state: 00 INACTIVE, 01 INIT, 10 ACTIVE, 11 treated as INACTIVE.
- ack_valid_i  in  1  ACK/NAK DLLP beat valid.
- ack_data_i  in  PIPE_DATA_WIDTH  ACK/NAK DLLP beat.
- ack_ready_o  out  1  ACK/NAK beat accepted this cycle.
- fc_valid_i  in  1  FC DLLP beat valid.
- fc_data_i  in  PIPE_DATA_WIDTH  FC DLLP beat.
- fc_ready_o  out  1  FC beat accepted.
- rpl_valid_i  in  1  replay TLP beat valid.
- rpl_data_i  in  PIPE_DATA_WIDTH  replay TLP beat.
- rpl_last_i  in  1  final beat of the replay TLP.
- rpl_ready_o  out  1  replay beat accepted.
- tlp_valid_i  in  1  new TLP beat valid.
- tlp_data_i  in  PIPE_DATA_WIDTH  new TLP beat.
- tlp_last_i  in  1  final beat of the new TLP.
- tlp_ready_o  out  1  new TLP beat accepted.
- pipe_txdata_o  out  PIPE_DATA_WIDTH  registered TX beat.
- pipe_txvalid_o  out  1  registered TX valid.
- fc_starved_o  out  1  FC promotion active (status).

Behaviour:
- Reset values: all outputs 0, state IDLE, fc_wait 0.
- Handshake:
  - A beat transfers when valid_i & ready_o in the same cycle.
  - ready_o is combinational from the current grant and never depends on the same source's data.
  - At most one ready_o is high per cycle.
- Latency:
  - An accepted beat appears on pipe_txdata_o/pipe_txvalid_o on the next sclk edge.
  - In a cycle with no accept, pipe_txvalid_o=0 and pipe_txdata_o holds its previous value.
- FSM states:
  - IDLE: packet boundary.
  - LOCK_RPL: mid replay TLP.
  - LOCK_TLP: mid new TLP.
- IDLE grant priority (ACTIVE state):
  - 1) fc if fc_wait == FC_MAX_WAIT.
  - 2) ack.
  - 3) rpl.
  - 4) tlp.
  - 5) fc.
- IDLE transitions:
  - On an accepted rpl beat with rpl_last_i=0: go to LOCK_RPL.
  - On an accepted tlp beat with tlp_last_i=0: go to LOCK_TLP.
  - A single-beat TLP (last=1 on its first beat) stays in IDLE.
- LOCK_RPL / LOCK_TLP:
  - Only the locked source is granted; DLLPs wait.
  - A cycle with locked valid=0 is a bubble: stay locked, pipe_txvalid_o=0.
  - An accepted beat with last=1 returns the FSM to IDLE; arbitration resumes the cycle after the last beat.
- Replay precedence:
  - While rpl_valid_i=1 in IDLE, tlp is never granted.
- DLCMSM gating:
  - INACTIVE: no grants; the FSM is forced to IDLE the same cycle. A mid-packet TLP is abandoned and the source must restart it.
  - INIT: only fc is granted; ack/rpl/tlp ready stay 0.
  - A change to INACTIVE takes effect on the same cycle's ready_o.
- FC wait counter:
  - Increments (saturating at FC_MAX_WAIT) each cycle fc_valid_i=1 and fc_ready_o=0.
  - Clears to 0 on an fc accept or when fc_valid_i=0.
  - fc_starved_o = (fc_wait == FC_MAX_WAIT).
  - Promotion applies only at IDLE; it never breaks a locked packet.
- Simultaneous events:
  - The last beat of a locked packet and a new request in the same cycle: the new request is granted next cycle at the earliest. No back-to-back grant in the same cycle.
- srst assertion mid-packet: immediate return to reset values.

Decomposition:
- Shared package dll_pkg:
  - typedef enum dlcm_state_t {DL_INACTIVE=2'b00, DL_INIT=2'b01, DL_ACTIVE=2'b10}.
  - typedef enum tx_arb_state_t {IDLE, LOCK_RPL, LOCK_TLP}.
  - Source-index localparams.
- One natural sub-module, dll_tx_fc_aging: FC wait counter plus promote flag.
- The grant mux stays inline.

Test Plan:
- ACTIVE; tlp 3-beat packet (last on beat 3) with ack_valid_i raised at beat 2:
  - ack_ready_o stays 0 until tlp beat 3 is accepted.
  - ack beat is granted the following cycle.
  - pipe_txvalid_o is 1 for 4 consecutive cycles, delayed 1 cycle from the accepts.
- ACTIVE; rpl and tlp both valid in IDLE:
  - rpl granted until its last beat.
  - tlp granted only once rpl_valid_i=0.
- FC_MAX_WAIT=4; fc_valid_i held with a continuous stream of 2-beat tlp packets:
  - fc_starved_o=1 after 4 waiting cycles.
  - fc granted at the next IDLE ahead of ack and tlp.
  - fc_wait returns to 0.
- dlcmsm_i=INIT with ack, tlp and fc all valid:
  - only fc_ready_o asserts.
  - ack and tlp readies stay 0 until dlcmsm_i=ACTIVE.
- dlcmsm_i drops to INACTIVE on beat 2 of a 4-beat tlp:
  - tlp_ready_o=0 that cycle; FSM to IDLE.
  - on return to ACTIVE, a fresh packet's first beat is accepted from IDLE.
- srst pulsed mid-LOCK_RPL:
  - outputs 0 asynchronously; FSM IDLE; fc_wait=0.
  - first beat after release is arbitrated from IDLE.
